// File: rtl/clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clock_pkg: shared types, BCD limits and field stepping for clock_ctrl |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  typedef struct packed {
    logic [3:0] h2;
    logic [3:0] h1;
    logic [3:0] m2;
    logic [3:0] m1;
    logic [3:0] s2;
    logic [3:0] s1;
  } time_t;

  // Values at or above max, or with a non-decimal digit, fall back to 00.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] value, input logic [7:0] max);
    logic [7:0] w_next;
    if (value[7:4] > 4'd9 || value[3:0] > 4'd9 || value >= max)
      w_next = 8'h00;
    else if (value[3:0] == 4'd9)
      w_next = {value[7:4] + 4'd1, 4'd0};
    else
      w_next = {value[7:4], value[3:0] + 4'd1};
    return w_next;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_ctrl_btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce: 2-FF synchroniser, stability counter, press pulse      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int c_cnt_w = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic               r_level_d;
  logic               r_press;
  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      // Any return to the accepted level restarts the stability run.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/clock_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clock_ctrl: 1 Hz trigger, button debounce and time-set FSM           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode_btn,
  input  logic        inc_btn,
  input  logic [23:0] cur_time,
  output logic        trigger,
  output logic        load_en,
  output logic [23:0] load_time,
  output logic [1:0]  edit_field,
  output logic        blink
);

  localparam int c_pw   = $clog2(TICK_DIV);
  localparam int c_half = TICK_DIV / 2;
  localparam int c_bw   = (c_half > 1) ? $clog2(c_half) : 1;
  localparam logic [c_pw-1:0] c_presc_last = c_pw'(TICK_DIV - 1);
  localparam logic [c_bw-1:0] c_blink_last = c_bw'(c_half - 1);

  logic            w_mode_ev;
  logic            w_inc_ev;
  state_t          r_state;
  time_t           r_edit;
  logic [c_pw-1:0] r_presc;
  logic [c_bw-1:0] r_bcnt;
  logic            r_trigger;
  logic            r_load_en;
  logic            r_blink;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (mode_btn),
    .press (w_mode_ev)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (inc_btn),
    .press (w_inc_ev)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_edit    <= '0;
      r_presc   <= '0;
      r_bcnt    <= '0;
      r_trigger <= 1'b0;
      r_load_en <= 1'b0;
      r_blink   <= 1'b0;
    end else begin
      r_trigger <= 1'b0;
      r_load_en <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_mode_ev) begin
            r_state <= ST_SET_H;
            r_edit  <= time_t'(cur_time);
            r_presc <= '0;
          end else if (r_presc == c_presc_last) begin
            r_presc   <= '0;
            r_trigger <= 1'b1;
          end else begin
            r_presc <= r_presc + c_pw'(1);
          end
        end
        ST_SET_H: begin
          if (w_mode_ev)
            r_state <= ST_SET_M;
          else if (w_inc_ev)
            {r_edit.h2, r_edit.h1} <= bcd2_inc({r_edit.h2, r_edit.h1}, HOUR_MAX);
        end
        ST_SET_M: begin
          if (w_mode_ev)
            r_state <= ST_SET_S;
          else if (w_inc_ev)
            {r_edit.m2, r_edit.m1} <= bcd2_inc({r_edit.m2, r_edit.m1}, MINSEC_MAX);
        end
        ST_SET_S: begin
          if (w_mode_ev) begin
            r_state   <= ST_RUN;
            r_load_en <= 1'b1;
          end else if (w_inc_ev) begin
            {r_edit.s2, r_edit.s1} <= bcd2_inc({r_edit.s2, r_edit.s1}, MINSEC_MAX);
          end
        end
      endcase

      // Blink phase restarts on every state change so each field starts visible-off.
      if (w_mode_ev || r_state == ST_RUN) begin
        r_blink <= 1'b0;
        r_bcnt  <= '0;
      end else if (r_bcnt == c_blink_last) begin
        r_blink <= ~r_blink;
        r_bcnt  <= '0;
      end else begin
        r_bcnt <= r_bcnt + c_bw'(1);
      end
    end
  end

  assign trigger    = r_trigger;
  assign load_en    = r_load_en;
  assign load_time  = r_edit;
  assign edit_field = r_state;
  assign blink      = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_clock_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_clock_ctrl: randomized self-checking bench with reference model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_clock_ctrl;

  localparam int TICK_DIV = 10;
  localparam int DEB      = 4;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        mode_btn = 1'b0;
  logic        inc_btn  = 1'b0;
  logic [23:0] cur_time = 24'h0;
  logic        trigger;
  logic        load_en;
  logic [23:0] load_time;
  logic [1:0]  edit_field;
  logic        blink;

  clock_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_btn   (mode_btn),
    .inc_btn    (inc_btn),
    .cur_time   (cur_time),
    .trigger    (trigger),
    .load_en    (load_en),
    .load_time  (load_time),
    .edit_field (edit_field),
    .blink      (blink)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          mode_at = -1;
  int          inc_at  = -1;
  int          m_state = 0;
  int          m_run   = 0;
  int          m_set   = 0;
  logic [23:0] m_edit  = 24'h0;
  logic        m_trig  = 1'b0;
  logic        m_load  = 1'b0;
  logic        m_blink = 1'b0;
  int          dut_loads = 0;
  int          dut_trigs = 0;
  logic [23:0] dut_load  = 24'h0;
  int          loads0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Two-digit decimal step with wrap at lim; anything invalid or out of range restarts at 0.
  function automatic logic [7:0] bump(input logic [7:0] v, input int lim);
    int d;
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return 8'h00;
    d = int'(v[7:4]) * 10 + int'(v[3:0]);
    d = (d + 1 >= lim) ? 0 : d + 1;
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  function automatic logic [23:0] rand_time();
    int h, m, s;
    if ($urandom_range(0, 4) == 0) return 24'($urandom);
    h = $urandom_range(0, 23);
    m = $urandom_range(0, 59);
    s = $urandom_range(0, 59);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_step();
    logic ev_mode, ev_inc;
    cyc++;
    m_trig = 1'b0;
    m_load = 1'b0;
    if (!rst_n) begin
      m_state = 0; m_run = 0; m_set = 0; m_edit = 24'h0; m_blink = 1'b0;
      mode_at = -1; inc_at = -1;
    end else begin
      ev_mode = (cyc == mode_at);
      ev_inc  = (cyc == inc_at) && !ev_mode;
      if (ev_mode) begin
        if (m_state == 0) m_edit = cur_time;
        if (m_state == 3) m_load = 1'b1;
        m_state = (m_state + 1) % 4;
        m_run = 0; m_set = 0; m_blink = 1'b0;
      end else if (m_state == 0) begin
        m_run++;
        m_trig  = (m_run % TICK_DIV) == 0;
        m_blink = 1'b0;
      end else begin
        if (ev_inc) begin
          case (m_state)
            1: m_edit[23:16] = bump(m_edit[23:16], 24);
            2: m_edit[15:8]  = bump(m_edit[15:8], 60);
            default: m_edit[7:0] = bump(m_edit[7:0], 60);
          endcase
        end
        m_set++;
        m_blink = ((m_set / (TICK_DIV / 2)) % 2) == 1;
      end
    end
    if (trigger) dut_trigs++;
    if (load_en) begin dut_loads++; dut_load = load_time; end
    chk("trigger", 32'(trigger), 32'(m_trig));
    chk("load_en", 32'(load_en), 32'(m_load));
    chk("edit_field", 32'(edit_field), 32'(m_state));
    chk("blink", 32'(blink), 32'(m_blink));
    chk("load_time", 32'(load_time), 32'(m_edit));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    @(negedge clk);
  endtask

  task automatic press(input bit m, input bit i);
    if (m) mode_at = cyc + DEB + 4;
    if (i) inc_at  = cyc + DEB + 4;
    mode_btn = m;
    inc_btn  = i;
    repeat (DEB + 5) cycle();
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    repeat (DEB + 5) cycle();
  endtask

  task automatic glitch(input int len);
    inc_btn = 1'b1;
    repeat (len) cycle();
    inc_btn = 1'b0;
    repeat (DEB + 5) cycle();
  endtask

  initial begin
    repeat (3) cycle();
    rst_n = 1'b1;

    dut_trigs = 0;
    repeat (100) cycle();
    chk("idle_trig_count", 32'(dut_trigs), 32'd10);

    cur_time = 24'h123059;
    press(1, 0);
    repeat (12) press(0, 1);
    loads0 = dut_loads;
    repeat (3) press(1, 0);
    chk("wrap_load_count", 32'(dut_loads - loads0), 32'd1);
    chk("wrap_load_value", 32'(dut_load), 32'h003059);

    cur_time = 24'h095959;
    press(1, 0); press(0, 1);
    press(1, 0); press(0, 1);
    press(1, 0); press(0, 1);
    press(1, 0);
    chk("no_carry_value", 32'(dut_load), 32'h100000);

    cur_time = 24'h271234;
    press(1, 0); press(0, 1);
    repeat (3) press(1, 0);
    chk("hour27_value", 32'(dut_load), 32'h001234);
    cur_time = 24'h3A4501;
    press(1, 0); press(0, 1);
    repeat (3) press(1, 0);
    chk("hour3A_value", 32'(dut_load), 32'h004501);

    cur_time = 24'h081517;
    press(1, 0);
    repeat (3) glitch(3);
    chk("glitch_edit", 32'(load_time), 32'h081517);
    press(1, 1);
    chk("both_field", 32'(edit_field), 32'd2);
    press(1, 0); press(1, 0);
    chk("both_value", 32'(dut_load), 32'h081517);

    cur_time = 24'h010203;
    press(1, 0); press(1, 0); press(0, 1);
    loads0 = dut_loads;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_trigger", 32'(trigger), 32'd0);
    chk("arst_load_en", 32'(load_en), 32'd0);
    chk("arst_field", 32'(edit_field), 32'd0);
    chk("arst_blink", 32'(blink), 32'd0);
    chk("arst_load_time", 32'(load_time), 32'd0);
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (30) cycle();
    chk("arst_no_load", 32'(dut_loads - loads0), 32'd0);

    repeat (150) begin
      int r;
      r = $urandom_range(0, 9);
      cur_time = rand_time();
      if (r <= 2)      press(1, 0);
      else if (r <= 6) press(0, 1);
      else if (r == 7) press(1, 1);
      else if (r == 8) glitch($urandom_range(1, DEB - 1));
      else             repeat ($urandom_range(1, 25)) cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_ctrl.md
# clock_ctrl

Controller for the BCD digital-clock counter. Generates the one-second `trigger` pulse, debounces the two front-panel buttons, and runs the time-set state machine: it captures the counter's current time, lets the user step hours, minutes and seconds, then loads the edited value back. It sits between the board I/O and the clock counter, and drives the display blink.

## Interface
Parameters:
- `TICK_DIV`, 100_000_000: clk cycles per tick (1 Hz at 100 MHz); minimum 2.
- `DEB_CYCLES`, 1_000_000: consecutive stable synchronised cycles before a button level is accepted; minimum 1.

Ports:
- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `mode_btn`  in  1  raw, asynchronous, active-high mode button
- `inc_btn`  in  1  raw, asynchronous, active-high increment button
- `cur_time`  in  24  live counter value {h2,h1,m2,m1,s2,s1}, 4-bit BCD each
- `trigger`  out  1  one-cycle advance pulse to the counter
- `load_en`  out  1  one-cycle load strobe to the counter
- `load_time`  out  24  value to load, same packing as `cur_time`
- `edit_field`  out  2  0 = none, 1 = hours, 2 = minutes, 3 = seconds
- `blink`  out  1  display blanking for the edited field

## Operation
- Reset values: all outputs 0, state RUN, prescaler 0, edit register 0, debouncers idle at level 0.
- Each button path: 2-FF synchroniser, then a stability counter. The accepted level changes only after `DEB_CYCLES` stable cycles. A press event is the accepted level's 0→1 edge.
- States:
  - RUN → SET_H on a mode event. Capture `cur_time` into the edit register.
  - SET_H → SET_M → SET_S on mode events.
  - SET_S → RUN on a mode event. Pulse `load_en` with `load_time` = edit register.
- `edit_field` equals the state encoding: RUN = 0, SET_H = 1, SET_M = 2, SET_S = 3.
- Inc event in a SET state: increment the selected field as a 2-digit BCD value.
  - Hours count 00..23; 23 → 00. Carries 09 → 10 and 19 → 20.
  - Minutes and seconds count 00..59; 59 → 00.
  - No carry into any other field.
  - Any captured value that is out of range or non-BCD (e.g. hour 3A or 27) increments to 00.
- Inc event in RUN: ignored.
- Mode and inc events in the same cycle: mode wins, inc is dropped.
- Prescaler:
  - Counts only in RUN. `trigger` fires when the count reaches `TICK_DIV`-1, then the count wraps to 0.
  - Held at 0 in all SET states; no `trigger` is issued there.
- `blink`: 0 in RUN; toggles every `TICK_DIV`/2 cycles in SET states. Reset to 0 on each state change.
- `load_time` holds the edit register continuously. It is only meaningful while `load_en` = 1.
- Reset asserted mid-edit: return to RUN immediately, no `load_en`, edits discarded.

## Timing
- Raw button rise (held stable) to press event: exactly `DEB_CYCLES`+3 clk cycles. Bounce shorter than `DEB_CYCLES` produces no event.
- State and `edit_field` update in the cycle after the event.
- `cur_time` capture is registered on the same edge as the RUN→SET_H transition.
- Edit-register increment is visible one cycle after the inc event.
- `load_en`:
  - High for exactly 1 cycle, on the same edge as SET_S→RUN.
  - The counter samples `load_time` on the following edge.
  - The first `trigger` after a load occurs `TICK_DIV` cycles after `load_en`.
- In RUN, `trigger` period is exactly `TICK_DIV` cycles and pulse width exactly 1 cycle. `trigger` and `load_en` are never high together.

## Structure
- Package `clock_pkg`:
  - state enum (`ST_RUN`, `ST_SET_H`, `ST_SET_M`, `ST_SET_S`)
  - field codes
  - BCD limits `HOUR_MAX` = 8'h23, `MINSEC_MAX` = 8'h59
  - packed time struct {h2,h1,m2,m1,s2,s1}
  - function `bcd2_inc(value, max)`
- Sub-module `btn_debounce`: synchroniser, stability counter, edge pulse; parameter `DEB_CYCLES`. Instantiated twice.

## Test plan
All scenarios use `TICK_DIV`=10, `DEB_CYCLES`=4.
- Release reset, idle 100 cycles → `trigger` pulses at cycles 10, 20, …, each 1 cycle wide; `load_en`, `edit_field` and `blink` stay 0.
- `cur_time`=12:30:59; press mode once, inc 12 times → hours read 00. Press mode 3 more times → exactly one `load_en` with `load_time`=00:30:59. First `trigger` follows 10 cycles later.
- Capture 09:59:59; inc once in each of SET_H, SET_M and SET_S → `load_time`=10:00:00 (no cross-field carry).
- Capture hour 8'h27 or 8'h3A; one inc → hour 00.
- 3-cycle glitches on `inc_btn` in a SET state → no increment. Mode and inc pressed together → state advances, field unchanged.
- Assert `rst_n` low in SET_M → all outputs 0 asynchronously, state RUN, no `load_en` after release.
